// File: rtl/pampy_bytecode_fetch_if.sv
// Fetch-unit bus for pamPy: program-memory read port, instruction handshake to the
// datapath, regJump redirect and FSM state visibility. master = fetch unit.
interface pampy_bytecode_fetch_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12,
    parameter int ULA_WIDTH  = 24
);
    logic                  fetch_en;
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  instr_valid;
    logic                  instr_ready;
    logic [DATA_WIDTH-1:0] instr_opcode;
    logic [ULA_WIDTH-1:0]  instr_arg;
    logic [ADDR_WIDTH-1:0] instr_pc;
    logic                  jump_en;
    logic [ADDR_WIDTH-1:0] jump_addr;
    logic [1:0]            dbg_state;

    modport master (
        input  fetch_en, mem_rdata, instr_ready, jump_en, jump_addr,
        output mem_rd_en, mem_addr, instr_valid, instr_opcode, instr_arg, instr_pc,
               dbg_state
    );

    modport slave (
        output fetch_en, mem_rdata, instr_ready, jump_en, jump_addr,
        input  mem_rd_en, mem_addr, instr_valid, instr_opcode, instr_arg, instr_pc,
               dbg_state
    );
endinterface

// File: rtl/pampy_bytecode_fetch.sv
// pamPy wordcode fetch: reads opcode/argument byte pairs and hands {opcode, arg, pc}
// to the datapath. Define PAMPY_EXTARG_EN to fold EXTENDED_ARG (144) prefixes.
module pampy_bytecode_fetch #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12,
    parameter int ULA_WIDTH  = 24,
    parameter int RESET_PC   = 0
) (
    input logic                      general_clk,
    input logic                      general_reset,
    pampy_bytecode_fetch_if.master   bus
);

    // Handshake: instr_valid rises with stable {opcode, arg, pc} and holds them until
    // a cycle with instr_ready=1 (transfer at that edge); jump_en overrides everything.
    localparam logic [1:0] S_OP   = 2'd0;
    localparam logic [1:0] S_ARG  = 2'd1;
    localparam logic [1:0] S_CAP  = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    localparam logic [DATA_WIDTH-1:0] OP_EXTENDED_ARG = DATA_WIDTH'(144);
    localparam logic [ADDR_WIDTH-1:0] PC_RESET        = ADDR_WIDTH'(RESET_PC);

    logic [1:0]            state_q,  state_d;
    logic [ADDR_WIDTH-1:0] pc_q,     pc_d;
    logic [DATA_WIDTH-1:0] op_q,     op_d;
    logic [ADDR_WIDTH-1:0] op_pc_q,  op_pc_d;
    logic                  valid_q,  valid_d;
    logic [DATA_WIDTH-1:0] opcode_q, opcode_d;
    logic [ULA_WIDTH-1:0]  arg_q,    arg_d;
    logic [ADDR_WIDTH-1:0] ipc_q,    ipc_d;
    logic                  rd_req;
    logic                  is_prefix;
    logic [ULA_WIDTH-1:0]  arg_folded;

`ifdef PAMPY_EXTARG_EN
    logic [ULA_WIDTH-1:0]  ext_acc_q, ext_acc_d;
    assign is_prefix = (op_q == OP_EXTENDED_ARG);
`else
    logic [ULA_WIDTH-1:0]  ext_acc_q;
    assign ext_acc_q = '0;
    assign is_prefix = 1'b0;
`endif

    // Older prefix bytes shift out of the top once ULA_WIDTH is exceeded.
    assign arg_folded = ULA_WIDTH'({ext_acc_q, bus.mem_rdata});

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        op_d     = op_q;
        op_pc_d  = op_pc_q;
        valid_d  = valid_q;
        opcode_d = opcode_q;
        arg_d    = arg_q;
        ipc_d    = ipc_q;
        rd_req   = 1'b0;
`ifdef PAMPY_EXTARG_EN
        ext_acc_d = ext_acc_q;
`endif
        if (bus.jump_en) begin
            pc_d    = bus.jump_addr;
            state_d = S_OP;
            valid_d = 1'b0;
`ifdef PAMPY_EXTARG_EN
            ext_acc_d = '0;
`endif
        end else begin
            case (state_q)
                S_OP: begin
                    if (bus.fetch_en) begin
                        rd_req  = 1'b1;
                        pc_d    = pc_q + ADDR_WIDTH'(1);
                        op_pc_d = pc_q;
                        state_d = S_ARG;
                    end
                end
                S_ARG: begin
                    rd_req  = 1'b1;
                    op_d    = bus.mem_rdata;
                    pc_d    = pc_q + ADDR_WIDTH'(1);
                    state_d = S_CAP;
                end
                S_CAP: begin
                    if (is_prefix) begin
`ifdef PAMPY_EXTARG_EN
                        ext_acc_d = arg_folded;
`endif
                        state_d = S_OP;
                    end else begin
                        opcode_d = op_q;
                        arg_d    = arg_folded;
                        ipc_d    = op_pc_q;
                        valid_d  = 1'b1;
`ifdef PAMPY_EXTARG_EN
                        ext_acc_d = '0;
`endif
                        state_d  = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (bus.instr_ready) begin
                        valid_d = 1'b0;
                        state_d = S_OP;
                    end
                end
                default: state_d = S_OP;
            endcase
        end
    end

    always_ff @(posedge general_clk or negedge general_reset) begin
        if (!general_reset) begin
            state_q  <= S_OP;
            pc_q     <= PC_RESET;
            op_q     <= '0;
            op_pc_q  <= '0;
            valid_q  <= 1'b0;
            opcode_q <= '0;
            arg_q    <= '0;
            ipc_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            op_q     <= op_d;
            op_pc_q  <= op_pc_d;
            valid_q  <= valid_d;
            opcode_q <= opcode_d;
            arg_q    <= arg_d;
            ipc_q    <= ipc_d;
        end
    end

`ifdef PAMPY_EXTARG_EN
    always_ff @(posedge general_clk or negedge general_reset) begin
        if (!general_reset) begin
            ext_acc_q <= '0;
        end else begin
            ext_acc_q <= ext_acc_d;
        end
    end
`endif

    // rd_req is already clear on a jump; gating with reset keeps memory idle in reset.
    assign bus.mem_rd_en    = rd_req & general_reset;
    assign bus.mem_addr     = pc_q;
    assign bus.instr_valid  = valid_q;
    assign bus.instr_opcode = opcode_q;
    assign bus.instr_arg    = arg_q;
    assign bus.instr_pc     = ipc_q;
    assign bus.dbg_state    = state_q;

endmodule
